// File: rtl/pool2d_stream.sv
// pool2d_stream: streaming KxK max/average pooling with run-time kernel, stride and frame size.
// Average mode is built only when POOL2D_AVG_EN is defined; otherwise the engine is max-only.
module pool2d_stream #(
  parameter int DW   = 8,
  parameter int CH   = 4,
  parameter int KMAX = 4,
  parameter int WMAX = 256,
  parameter int HMAX = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_start,
  input  logic [$clog2(KMAX+1)-1:0] cfg_k,
  input  logic [$clog2(KMAX+1)-1:0] cfg_s,
  input  logic [$clog2(WMAX+1)-1:0] cfg_w,
  input  logic [$clog2(HMAX+1)-1:0] cfg_h,
  input  logic                      cfg_avg,
  output logic                      cfg_err,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CH*DW-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CH*DW-1:0]          out_data,
  output logic                      out_eol,
  output logic                      out_eof,
  output logic                      busy
);
  localparam int KW  = $clog2(KMAX+1);
  localparam int WW  = $clog2(WMAX+1);
  localparam int HW  = $clog2(HMAX+1);
  localparam int JW  = $clog2(WMAX);
  localparam int SLW = (KMAX > 2) ? $clog2(KMAX-1) : 1;
`ifdef POOL2D_AVG_EN
  localparam int SW = DW + 4;
`else
  localparam int SW = DW;
`endif

  // Handshake: a beat moves on a port only in a cycle where valid and ready are both high;
  // valid and its payload never change while waiting for ready.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2} state_t;
  state_t state, state_nx;

  logic [KW-1:0] k_r, s_r, sph, vph;
  logic [WW-1:0] w_r, c, k_m1_w;
  logic [HW-1:0] h_r, r, k_m1_h;
  logic [JW-1:0] hj;
  logic [SLW-1:0] wslot;
  logic cfg_ok, start_ok, accept, last_col, h_fire, v_row, eol_nx, eof_nx;

  logic [CH-1:0][DW-1:0] pix, res;
  logic [KMAX-2:0][CH-1:0][DW-1:0] sr;
  logic [CH-1:0][SW-1:0] lb [KMAX-1][WMAX];
  logic [CH-1:0][SW-1:0] h_store;
  logic [DW-1:0] hmax, vmax;
  logic [SW-1:0] ent;
  int slot;
`ifdef POOL2D_AVG_EN
  logic avg_r;
  logic [SW-1:0] hsum, vsum;
  logic [2:0] avg_sh;
`else
  logic unused_avg;
  assign unused_avg = cfg_avg;
`endif

  assign pix = in_data;

  always_comb begin
    cfg_ok = (cfg_k != '0) && (cfg_k <= KW'(KMAX)) && (cfg_s != '0) && (cfg_s <= cfg_k) &&
             (cfg_w >= WW'(cfg_k)) && (cfg_w <= WW'(WMAX)) &&
             (cfg_h >= HW'(cfg_k)) && (cfg_h <= HW'(HMAX));
`ifdef POOL2D_AVG_EN
    if (cfg_avg && !(cfg_k == KW'(1) || cfg_k == KW'(2) || cfg_k == KW'(4))) cfg_ok = 1'b0;
`endif
  end

  assign start_ok = (state == S_IDLE) && cfg_start && cfg_ok;
  assign accept   = in_valid && in_ready;
  assign k_m1_w   = WW'(k_r) - WW'(1);
  assign k_m1_h   = HW'(k_r) - HW'(1);
  assign last_col = (c == w_r - WW'(1));
  assign h_fire   = accept && (c >= k_m1_w) && (sph == '0);
  assign v_row    = (r >= k_m1_h) && (vph == '0);
  // A window is the last of its row/frame when the next aligned one would run past the edge.
  assign eol_nx   = (({1'b0, c} + (WW+1)'(s_r)) >= {1'b0, w_r});
  assign eof_nx   = eol_nx && (({1'b0, r} + (HW+1)'(s_r)) >= {1'b0, h_r});

  // FSM: state register / next state / outputs
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (cfg_start && cfg_ok) state_nx = S_RUN;
      S_RUN:   if (out_valid && out_ready && out_eof) state_nx = S_FLUSH;
      S_FLUSH: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == S_RUN);
    in_ready = (state == S_RUN) && !(out_valid && !out_ready);
  end

  // Horizontal reduce of the current pixel with the K-1 previous ones, then vertical
  // combine with the same column of the K-1 previous rows held in the line buffer.
  always_comb begin
    h_store = '0;
    res     = '0;
    hmax    = '0;
    vmax    = '0;
    ent     = '0;
    slot    = 0;
`ifdef POOL2D_AVG_EN
    hsum    = '0;
    vsum    = '0;
    avg_sh  = (k_r == KW'(4)) ? 3'd4 : (k_r == KW'(2)) ? 3'd2 : 3'd0;
`endif
    for (int ch = 0; ch < CH; ch++) begin
      hmax = pix[ch];
`ifdef POOL2D_AVG_EN
      hsum = SW'(pix[ch]);
`endif
      for (int d = 1; d < KMAX; d++) begin
        if (d < int'(k_r)) begin
          if (sr[d-1][ch] > hmax) hmax = sr[d-1][ch];
`ifdef POOL2D_AVG_EN
          hsum = hsum + SW'(sr[d-1][ch]);
`endif
        end
      end
`ifdef POOL2D_AVG_EN
      h_store[ch] = avg_r ? hsum : SW'(hmax);
      vsum = h_store[ch];
`else
      h_store[ch] = hmax;
`endif
      vmax = hmax;
      for (int d = 1; d < KMAX; d++) begin
        if (d < int'(k_r)) begin
          slot = int'(wslot) - d;
          if (slot < 0) slot = slot + (KMAX - 1);
          ent = lb[SLW'(slot)][hj][ch];
          if (ent[DW-1:0] > vmax) vmax = ent[DW-1:0];
`ifdef POOL2D_AVG_EN
          vsum = vsum + ent;
`endif
        end
      end
`ifdef POOL2D_AVG_EN
      res[ch] = avg_r ? DW'(vsum >> avg_sh) : vmax;
`else
      res[ch] = vmax;
`endif
    end
  end

  // Storage without reset: rows are always rewritten before they are read.
  always_ff @(posedge clk) begin
    if (accept) begin
      sr[0] <= pix;
      for (int d = 1; d < KMAX - 1; d++) sr[d] <= sr[d-1];
      if (h_fire) lb[wslot][hj] <= h_store;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_r <= '0; s_r <= '0; w_r <= '0; h_r <= '0;
      c <= '0; sph <= '0; hj <= '0; r <= '0; vph <= '0; wslot <= '0;
      cfg_err <= 1'b0;
      out_valid <= 1'b0; out_data <= '0; out_eol <= 1'b0; out_eof <= 1'b0;
`ifdef POOL2D_AVG_EN
      avg_r <= 1'b0;
`endif
    end else begin
      cfg_err <= (state == S_IDLE) && cfg_start && !cfg_ok;
      if (start_ok) begin
        k_r <= cfg_k; s_r <= cfg_s; w_r <= cfg_w; h_r <= cfg_h;
        c <= '0; sph <= '0; hj <= '0; r <= '0; vph <= '0; wslot <= '0;
`ifdef POOL2D_AVG_EN
        avg_r <= cfg_avg;
`endif
      end
      if (accept) begin
        if (last_col) begin
          c <= '0; sph <= '0; hj <= '0;
          r <= r + HW'(1);
          wslot <= (wslot == SLW'(KMAX - 2)) ? '0 : wslot + SLW'(1);
          if (r >= k_m1_h) vph <= (vph == s_r - KW'(1)) ? '0 : vph + KW'(1);
        end else begin
          c <= c + WW'(1);
          if (c >= k_m1_w) begin
            sph <= (sph == s_r - KW'(1)) ? '0 : sph + KW'(1);
            if (sph == '0) hj <= hj + JW'(1);
          end
        end
      end
      if (h_fire && v_row) begin
        out_valid <= 1'b1;
        out_data  <= res;
        out_eol   <= eol_nx;
        out_eof   <= eof_nx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pool2d_stream.sv
// Bench for pool2d_stream: directed and random frames against a window-arithmetic model,
// scoreboard queue popped by an output monitor, with backpressure, bad-config and reset cases.
`timescale 1ns/1ps
module tb_pool2d_stream;
  localparam int DW = 8, CH = 4, KMAX = 4, WMAX = 256, HMAX = 256;
  localparam int KW = $clog2(KMAX+1), WW = $clog2(WMAX+1), HW = $clog2(HMAX+1);
  localparam int PW = CH*DW;
  localparam int EW = PW + 2;

  logic clk, rst, cfg_start, cfg_avg, cfg_err;
  logic [KW-1:0] cfg_k, cfg_s;
  logic [WW-1:0] cfg_w;
  logic [HW-1:0] cfg_h;
  logic in_valid, in_ready, out_valid, out_ready, out_eol, out_eof, busy;
  logic [PW-1:0] in_data, out_data;

  logic [EW-1:0] exp_q[$];
  logic [PW-1:0] frm[$];
  int n_tests = 0, n_fail = 0;
  int rdy_mode = 0;
  logic [3:0] rdy_pat = 4'b1001;

  pool2d_stream #(.DW(DW), .CH(CH), .KMAX(KMAX), .WMAX(WMAX), .HMAX(HMAX)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_k(cfg_k), .cfg_s(cfg_s),
    .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_avg(cfg_avg), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_eol(out_eol), .out_eof(out_eof), .busy(busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "global timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit cfg_valid(int k, int s, int w, int h, bit avg);
    bit ok;
    ok = (k >= 1) && (k <= KMAX) && (s >= 1) && (s <= k) && (w >= k) && (w <= WMAX) &&
         (h >= k) && (h <= HMAX);
`ifdef POOL2D_AVG_EN
    if (avg && !(k == 1 || k == 2 || k == 4)) ok = 1'b0;
`else
    if (avg) ok = ok;
`endif
    return ok;
  endfunction

  // mode 0: ch0 = (row*W+col) mod 256, other channels random; 1: ch n = row*W+col+n; 2: random
  task automatic build_frame(input int mode, input int w, input int h);
    logic [PW-1:0] p;
    frm.delete();
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        for (int ch = 0; ch < CH; ch++) begin
          case (mode)
            0:       p[ch*DW +: DW] = (ch == 0) ? DW'((r*w + c) % 256) : DW'($urandom);
            1:       p[ch*DW +: DW] = DW'(r*w + c + ch);
            default: p[ch*DW +: DW] = DW'($urandom);
          endcase
        end
        frm.push_back(p);
      end
  endtask

  // Reference: every output window reduced directly from the stored frame.
  task automatic push_model(input int k, input int s, input int w, input int h, input bit avg);
    int ow, oh, mx, sm, v;
    bit use_avg;
    logic [PW-1:0] d, px;
`ifdef POOL2D_AVG_EN
    use_avg = avg;
`else
    use_avg = 1'b0;
`endif
    ow = (w - k) / s + 1;
    oh = (h - k) / s + 1;
    for (int i = 0; i < oh; i++)
      for (int j = 0; j < ow; j++) begin
        d = '0;
        for (int ch = 0; ch < CH; ch++) begin
          mx = 0; sm = 0;
          for (int dr = 0; dr < k; dr++)
            for (int dc = 0; dc < k; dc++) begin
              px = frm[(i*s + dr)*w + j*s + dc];
              v = int'(px[ch*DW +: DW]);
              if (v > mx) mx = v;
              sm += v;
            end
          d[ch*DW +: DW] = DW'(use_avg ? sm / (k*k) : mx);
        end
        exp_q.push_back({(j == ow-1) && (i == oh-1), j == ow-1, d});
      end
  endtask

  // Driver tasks: all start and end at #1 after a rising edge.
  task automatic start_cfg(input int k, input int s, input int w, input int h, input bit avg,
                           input bit exp_ok);
    cfg_k = KW'(k); cfg_s = KW'(s); cfg_w = WW'(w); cfg_h = HW'(h); cfg_avg = avg;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    check("cfg_err_on_start", cfg_err, !exp_ok);
    check("busy_on_start", busy, exp_ok);
    if (!exp_ok) begin
      @(posedge clk); #1;
      check("cfg_err_one_cycle", cfg_err, 0);
      check("busy_after_reject", busy, 0);
      check("in_ready_after_reject", in_ready, 0);
    end
  endtask

  task automatic drive_pixels(input int n, input bit gaps);
    int guard;
    bit acc, done;
    done = 1'b0;
    for (int i = 0; i < n && !done; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = frm[i];
      acc = 1'b0;
      guard = 0;
      while (!acc && !done) begin
        @(negedge clk);
        if (!busy) done = 1'b1;
        else if (in_ready) acc = 1'b1;
        @(posedge clk); #1;
        guard++;
        if (!acc && !done && guard > 400) begin
          n_tests++; n_fail++;
          $display("FAIL in_accept_timeout: pixel %0d not taken after %0d cycles, required within 400", i, guard);
          done = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy && g < 2000) begin @(posedge clk); #1; g++; end
    check("frame_done_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_frame(input int mode, input int k, input int s, input int w, input int h,
                           input bit avg, input bit gaps, input int rmode);
    bit ok;
    ok = cfg_valid(k, s, w, h, avg);
    rdy_mode = rmode;
    build_frame(mode, w, h);
    if (ok) push_model(k, s, w, h, avg);
    start_cfg(k, s, w, h, avg, ok);
    if (ok) begin
      drive_pixels(w*h, gaps);
      wait_idle();
    end
  endtask

  task automatic check_reset_vals();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_eol", out_eol, 0);
    check("rst_out_eof", out_eof, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_busy", busy, 0);
  endtask

  // out_ready generator: 0 = always ready, 1 = repeating 1-0-0-1, other = random
  initial begin
    int rcnt;
    rcnt = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = rdy_pat[rcnt % 4]; rcnt++; end
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted output beat, checks holding while stalled.
  initial begin
    logic [EW-1:0] held, got, e;
    bit holding;
    holding = 1'b0;
    forever begin
      @(negedge clk);
      got = {out_eof, out_eol, out_data};
      if (rst) begin
        holding = 1'b0;
      end else begin
        if (holding) begin
          check("stall_valid_held", out_valid, 1);
          check("stall_beat_stable", got, held);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_out: got 0x%0h, required no output", got);
          end else begin
            e = exp_q.pop_front();
            check("out_beat", got, e);
          end
        end
        holding = out_valid && !out_ready;
        held = got;
      end
    end
  end

  // Main sequence
  initial begin
    int k, s, w, h;
    bit avg;
    rst = 1'b1; cfg_start = 1'b0; cfg_k = '0; cfg_s = '0; cfg_w = '0; cfg_h = '0;
    cfg_avg = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_vals();

    // Max K=4 S=3 on 30x4: 93,96,...,117
    run_frame(0, 4, 3, 30, 4, 1'b0, 1'b0, 0);

    // Max K=2 S=2 on 4x4, channel n offset by n; cfg_start while busy must be ignored
    rdy_mode = 0;
    build_frame(1, 4, 4);
    push_model(2, 2, 4, 4, 1'b0);
    start_cfg(2, 2, 4, 4, 1'b0, 1'b1);
    cfg_k = KW'(5); cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    check("cfg_ignored_busy_err", cfg_err, 0);
    check("cfg_ignored_busy", busy, 1);
    drive_pixels(16, 1'b0);
    wait_idle();

    // Average K=2 on 4x2 (max when the average build is absent), then K=3 average
    run_frame(1, 2, 2, 4, 2, 1'b1, 1'b0, 0);
    run_frame(2, 3, 1, 6, 5, 1'b1, 1'b0, 0);

    // Backpressure: 1-0-0-1 ready pattern with input gaps, then random ready
    run_frame(0, 4, 3, 30, 4, 1'b0, 1'b1, 1);
    run_frame(2, 3, 1, 9, 6, 1'b0, 1'b1, 2);

    // Rejected configurations
    run_frame(2, 5, 1, 8, 8, 1'b0, 1'b0, 0);
    run_frame(2, 2, 3, 8, 8, 1'b0, 1'b0, 0);
    run_frame(2, 4, 1, 3, 8, 1'b0, 1'b0, 0);
    run_frame(2, 4, 1, 8, 3, 1'b0, 1'b0, 0);

    // Reset mid-frame after 40 pixels, then rerun the first frame
    rdy_mode = 0;
    build_frame(0, 30, 4);
    start_cfg(4, 3, 30, 4, 1'b0, 1'b1);
    drive_pixels(40, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_vals();
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_vals();
    run_frame(0, 4, 3, 30, 4, 1'b0, 1'b0, 0);

    // Random frames
    for (int t = 0; t < 10; t++) begin
      k = $urandom_range(1, KMAX);
      s = $urandom_range(1, k);
      w = $urandom_range(k, 14);
      h = $urandom_range(k, 8);
      avg = 1'($urandom_range(0, 1));
      if (k == 3) avg = 1'b0;
      run_frame(2, k, s, w, h, avg, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
